// File: rtl/axi_lite_master_queued.sv
// AXI4-Lite master with a request queue per direction and one transaction in
// flight per channel. Writes and reads are fully independent.
// Ports:
//   ACLK, ARESETN                 clock, async active-low reset
//   write_*_i / write_*_o         write request push, ready, pending count, done, BRESP
//   read_*_i  / read_*_o          read request push, ready, pending count, done, RDATA/RRESP
//   AW*/W*/B*, AR*/R*             AXI4-Lite master channels
module axi_lite_master_queued #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REQ_DEPTH      = 4,
   parameter int unsigned FLUSH_ON_ERROR = 1
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [ADDR_WIDTH-1:0]             write_address_i,
   input  logic [DATA_WIDTH-1:0]             write_data_i,
   input  logic [DATA_WIDTH/8-1:0]           write_strobe_i,
   input  logic                              write_start_i,
   output logic                              write_ready_o,
   output logic [$clog2(REQ_DEPTH+1)-1:0]    write_pending_o,
   output logic                              write_done_o,
   output logic [1:0]                        write_response_o,
   input  logic [ADDR_WIDTH-1:0]             read_address_i,
   input  logic                              read_start_i,
   output logic                              read_ready_o,
   output logic [$clog2(REQ_DEPTH+1)-1:0]    read_pending_o,
   output logic                              read_done_o,
   output logic [DATA_WIDTH-1:0]             read_data_o,
   output logic [1:0]                        read_response_o,
   output logic [ADDR_WIDTH-1:0]             AWADDR,
   output logic                              AWVALID,
   input  logic                              AWREADY,
   output logic [DATA_WIDTH-1:0]             WDATA,
   output logic [DATA_WIDTH/8-1:0]           WSTRB,
   output logic                              WVALID,
   input  logic                              WREADY,
   input  logic [1:0]                        BRESP,
   input  logic                              BVALID,
   output logic                              BREADY,
   output logic [ADDR_WIDTH-1:0]             ARADDR,
   output logic                              ARVALID,
   input  logic                              ARREADY,
   input  logic [DATA_WIDTH-1:0]             RDATA,
   input  logic [1:0]                        RRESP,
   input  logic                              RVALID,
   output logic                              RREADY
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W      = $clog2(REQ_DEPTH);
   localparam int unsigned PTR_FULL_W = PTR_W + 1;
   localparam int unsigned CNT_W      = $clog2(REQ_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
   } wr_req_t;

   typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

   // Responses are always accepted immediately.
   assign BREADY = 1'b1;
   assign RREADY = 1'b1;

   // ---------------- write direction ----------------
   wr_req_t                 wq_mem [REQ_DEPTH];
   logic [PTR_FULL_W-1:0]   wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
   logic                    wq_empty, wq_full, wq_push, wq_pop;
   wr_req_t                 wq_head;
   wr_state_e               wst_q, wst_d;
   logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [1:0]              wresp_q, wresp_d;
   logic                    wdone_q, wdone_d;
   logic [CNT_W-1:0]        wpend_q, wpend_d;
   logic                    w_resp_hs, w_flush;

   // Extra pointer MSB separates full from empty when the indices match.
   assign wq_empty  = (wq_wptr_q == wq_rptr_q);
   assign wq_full   = (wq_wptr_q[PTR_W] != wq_rptr_q[PTR_W]) &&
                      (wq_wptr_q[PTR_W-1:0] == wq_rptr_q[PTR_W-1:0]);
   assign wq_head   = wq_mem[wq_rptr_q[PTR_W-1:0]];
   assign w_resp_hs = (wst_q == W_RESP) && BVALID;
   assign w_flush   = (FLUSH_ON_ERROR != 0) && w_resp_hs && BRESP[1];
   assign write_ready_o = !wq_full && !w_flush;
   assign wq_push   = write_start_i && write_ready_o;

   always_ff @(posedge ACLK) begin
      if (wq_push) wq_mem[wq_wptr_q[PTR_W-1:0]] <= '{addr: write_address_i, data: write_data_i, strb: write_strobe_i};
   end

   // Write FSM, queue pointers and pending count.
   always_comb begin
      wst_d     = wst_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wresp_d   = wresp_q;
      wdone_d   = 1'b0;
      wq_pop    = 1'b0;
      case (wst_q)
         W_IDLE: begin
            if (!wq_empty) begin
               wq_pop    = 1'b1;
               awaddr_d  = wq_head.addr;
               wdata_d   = wq_head.data;
               wstrb_d   = wq_head.strb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               wst_d     = W_ADDR_DATA;
            end
         end
         W_ADDR_DATA: begin
            if (awvalid_q && AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) wst_d = W_RESP;
         end
         W_RESP: begin
            if (BVALID) begin
               wresp_d = BRESP;
               wdone_d = 1'b1;
               wst_d   = W_IDLE;
            end
         end
         default: wst_d = W_IDLE;
      endcase

      wq_wptr_d = wq_wptr_q;
      wq_rptr_d = wq_rptr_q;
      if (wq_push) wq_wptr_d = wq_wptr_q + PTR_FULL_W'(1);
      if (w_flush)     wq_rptr_d = wq_wptr_q;
      else if (wq_pop) wq_rptr_d = wq_rptr_q + PTR_FULL_W'(1);

      wpend_d = wpend_q;
      if (w_flush)                     wpend_d = '0;
      else if (wq_push && !w_resp_hs)  wpend_d = wpend_q + CNT_W'(1);
      else if (!wq_push && w_resp_hs)  wpend_d = wpend_q - CNT_W'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wst_q     <= W_IDLE;
         wq_wptr_q <= '0;
         wq_rptr_q <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wresp_q   <= 2'b00;
         wdone_q   <= 1'b0;
         wpend_q   <= '0;
      end else begin
         wst_q     <= wst_d;
         wq_wptr_q <= wq_wptr_d;
         wq_rptr_q <= wq_rptr_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wresp_q   <= wresp_d;
         wdone_q   <= wdone_d;
         wpend_q   <= wpend_d;
      end
   end

   assign AWADDR           = awaddr_q;
   assign AWVALID          = awvalid_q;
   assign WDATA            = wdata_q;
   assign WSTRB            = wstrb_q;
   assign WVALID           = wvalid_q;
   assign write_done_o     = wdone_q;
   assign write_response_o = wresp_q;
   assign write_pending_o  = wpend_q;

   // ---------------- read direction ----------------
   logic [ADDR_WIDTH-1:0]   rq_mem [REQ_DEPTH];
   logic [PTR_FULL_W-1:0]   rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
   logic                    rq_empty, rq_full, rq_push, rq_pop;
   rd_state_e               rst_q, rst_d;
   logic                    arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rdone_q, rdone_d;
   logic [CNT_W-1:0]        rpend_q, rpend_d;
   logic                    r_resp_hs, r_flush;

   assign rq_empty  = (rq_wptr_q == rq_rptr_q);
   assign rq_full   = (rq_wptr_q[PTR_W] != rq_rptr_q[PTR_W]) &&
                      (rq_wptr_q[PTR_W-1:0] == rq_rptr_q[PTR_W-1:0]);
   assign r_resp_hs = (rst_q == R_DATA) && RVALID;
   assign r_flush   = (FLUSH_ON_ERROR != 0) && r_resp_hs && RRESP[1];
   assign read_ready_o = !rq_full && !r_flush;
   assign rq_push   = read_start_i && read_ready_o;

   always_ff @(posedge ACLK) begin
      if (rq_push) rq_mem[rq_wptr_q[PTR_W-1:0]] <= read_address_i;
   end

   // Read FSM, queue pointers and pending count.
   always_comb begin
      rst_d     = rst_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rdone_d   = 1'b0;
      rq_pop    = 1'b0;
      case (rst_q)
         R_IDLE: begin
            if (!rq_empty) begin
               rq_pop    = 1'b1;
               araddr_d  = rq_mem[rq_rptr_q[PTR_W-1:0]];
               arvalid_d = 1'b1;
               rst_d     = R_ADDR;
            end
         end
         R_ADDR: begin
            if (ARREADY) begin
               arvalid_d = 1'b0;
               rst_d     = R_DATA;
            end
         end
         R_DATA: begin
            if (RVALID) begin
               rdata_d = RDATA;
               rresp_d = RRESP;
               rdone_d = 1'b1;
               rst_d   = R_IDLE;
            end
         end
         default: rst_d = R_IDLE;
      endcase

      rq_wptr_d = rq_wptr_q;
      rq_rptr_d = rq_rptr_q;
      if (rq_push) rq_wptr_d = rq_wptr_q + PTR_FULL_W'(1);
      if (r_flush)     rq_rptr_d = rq_wptr_q;
      else if (rq_pop) rq_rptr_d = rq_rptr_q + PTR_FULL_W'(1);

      rpend_d = rpend_q;
      if (r_flush)                     rpend_d = '0;
      else if (rq_push && !r_resp_hs)  rpend_d = rpend_q + CNT_W'(1);
      else if (!rq_push && r_resp_hs)  rpend_d = rpend_q - CNT_W'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rst_q     <= R_IDLE;
         rq_wptr_q <= '0;
         rq_rptr_q <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         rdone_q   <= 1'b0;
         rpend_q   <= '0;
      end else begin
         rst_q     <= rst_d;
         rq_wptr_q <= rq_wptr_d;
         rq_rptr_q <= rq_rptr_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rdone_q   <= rdone_d;
         rpend_q   <= rpend_d;
      end
   end

   assign ARADDR          = araddr_q;
   assign ARVALID         = arvalid_q;
   assign read_data_o     = rdata_q;
   assign read_response_o = rresp_q;
   assign read_done_o     = rdone_q;
   assign read_pending_o  = rpend_q;

endmodule

// File: tb/tb_axi_lite_master_queued.sv
// Scoreboard bench for axi_lite_master_queued: stimulus pushes expected
// AW/W/AR beats and responses; a negedge slave/monitor pops and compares.
module tb_axi_lite_master_queued;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 3;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;

   logic [AW-1:0] write_address_i = '0;
   logic [DW-1:0] write_data_i = '0;
   logic [SW-1:0] write_strobe_i = '0;
   logic          write_start_i = 1'b0;
   logic          write_ready_o, write_done_o;
   logic [CW-1:0] write_pending_o;
   logic [1:0]    write_response_o;
   logic [AW-1:0] read_address_i = '0;
   logic          read_start_i = 1'b0;
   logic          read_ready_o, read_done_o;
   logic [CW-1:0] read_pending_o;
   logic [DW-1:0] read_data_o;
   logic [1:0]    read_response_o;
   logic [AW-1:0] AWADDR, ARADDR;
   logic          AWVALID, WVALID, ARVALID, BREADY, RREADY;
   logic [DW-1:0] WDATA;
   logic [SW-1:0] WSTRB;
   logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
   logic [1:0]    BRESP = 2'b00, RRESP = 2'b00;
   logic [DW-1:0] RDATA = '0;

   axi_lite_master_queued #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(4), .FLUSH_ON_ERROR(1)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .write_address_i(write_address_i), .write_data_i(write_data_i), .write_strobe_i(write_strobe_i),
      .write_start_i(write_start_i), .write_ready_o(write_ready_o), .write_pending_o(write_pending_o),
      .write_done_o(write_done_o), .write_response_o(write_response_o),
      .read_address_i(read_address_i), .read_start_i(read_start_i), .read_ready_o(read_ready_o),
      .read_pending_o(read_pending_o), .read_done_o(read_done_o), .read_data_o(read_data_o),
      .read_response_o(read_response_o),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard queues (expected) and slave response queues.
   logic [AW-1:0]    exp_aw_q[$];
   logic [DW+SW-1:0] exp_w_q[$];
   logic [1:0]       exp_b_q[$];
   logic [1:0]       slv_b_q[$];
   logic [AW-1:0]    exp_ar_q[$];
   logic [DW+1:0]    exp_r_q[$];
   logic [DW+1:0]    slv_r_q[$];

   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   bit aw_seen = 0, w_seen = 0, ar_seen = 0;
   int wdone_cnt = 0, rdone_cnt = 0, ar_hs_cnt = 0, awvalid_cycles = 0;

   // Slave model and output monitor; drives and samples on the falling edge.
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
         aw_seen = 0; w_seen = 0; ar_seen = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         if (write_done_o || read_done_o) chk("done_in_reset", 64'(1), 64'(0));
      end else begin
         if (write_done_o) begin
            wdone_cnt++;
            if (exp_b_q.size() == 0) chk("wr_done_unexpected", 64'(1), 64'(0));
            else chk("wr_resp", 64'(write_response_o), 64'(exp_b_q.pop_front()));
         end
         if (read_done_o) begin
            rdone_cnt++;
            if (exp_r_q.size() == 0) chk("rd_done_unexpected", 64'(1), 64'(0));
            else chk("rd_data_resp", 64'({read_data_o, read_response_o}), 64'(exp_r_q.pop_front()));
         end
         if (AWVALID) awvalid_cycles++;
         // AW channel
         if (AWREADY) begin
            AWREADY = 1'b0; aw_seen = 1; aw_cnt = 0;
         end else if (AWVALID) begin
            if (aw_cnt >= aw_wait) begin
               AWREADY = 1'b1;
               if (exp_aw_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
               else chk("awaddr", 64'(AWADDR), 64'(exp_aw_q.pop_front()));
            end else aw_cnt++;
         end else if (aw_cnt != 0) begin
            chk("awvalid_held", 64'(0), 64'(1));
            aw_cnt = 0;
         end
         // W channel
         if (WREADY) begin
            WREADY = 1'b0; w_seen = 1; w_cnt = 0;
         end else if (WVALID) begin
            if (w_cnt >= w_wait) begin
               WREADY = 1'b1;
               if (exp_w_q.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
               else chk("wdata_wstrb", 64'({WDATA, WSTRB}), 64'(exp_w_q.pop_front()));
            end else w_cnt++;
         end else if (w_cnt != 0) begin
            chk("wvalid_held", 64'(0), 64'(1));
            w_cnt = 0;
         end
         // B channel
         if (BVALID) BVALID = 1'b0;
         else if (aw_seen && w_seen) begin
            if (b_cnt >= b_wait) begin
               chk("bready", 64'(BREADY), 64'(1));
               BVALID = 1'b1;
               BRESP = (slv_b_q.size() != 0) ? slv_b_q.pop_front() : 2'b00;
               aw_seen = 0; w_seen = 0; b_cnt = 0;
            end else b_cnt++;
         end
         // AR channel
         if (ARREADY) begin
            ARREADY = 1'b0; ar_seen = 1; ar_cnt = 0; ar_hs_cnt++;
         end else if (ARVALID) begin
            if (ar_cnt >= ar_wait) begin
               ARREADY = 1'b1;
               if (exp_ar_q.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
               else chk("araddr", 64'(ARADDR), 64'(exp_ar_q.pop_front()));
            end else ar_cnt++;
         end
         // R channel
         if (RVALID) RVALID = 1'b0;
         else if (ar_seen) begin
            if (r_cnt >= r_wait) begin
               chk("rready", 64'(RREADY), 64'(1));
               RVALID = 1'b1;
               {RDATA, RRESP} = (slv_r_q.size() != 0) ? slv_r_q.pop_front() : '0;
               ar_seen = 0; r_cnt = 0;
            end else r_cnt++;
         end
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic [1:0] resp, input bit exp_acc);
      logic acc;
      @(negedge ACLK);
      write_address_i = a; write_data_i = d; write_strobe_i = s; write_start_i = 1'b1;
      #2;
      acc = write_ready_o;
      chk("wr_accept", 64'(acc), 64'(exp_acc));
      if (acc) begin
         exp_aw_q.push_back(a); exp_w_q.push_back({d, s});
         exp_b_q.push_back(resp); slv_b_q.push_back(resp);
      end
      @(posedge ACLK);
      #1 write_start_i = 1'b0;
   endtask

   task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp,
                          input bit track);
      logic acc;
      @(negedge ACLK);
      read_address_i = a; read_start_i = 1'b1;
      #2;
      acc = read_ready_o;
      chk("rd_accept", 64'(acc), 64'(1));
      if (acc && track) begin
         exp_ar_q.push_back(a); exp_r_q.push_back({d, resp}); slv_r_q.push_back({d, resp});
      end
      @(posedge ACLK);
      #1 read_start_i = 1'b0;
   endtask

   task automatic wait_wdone(input int target);
      int t = 0;
      while (wdone_cnt < target && t < 500) begin
         @(negedge ACLK); #1; t++;
      end
      chk("wr_done_timeout", 64'(wdone_cnt >= target), 64'(1));
   endtask

   task automatic wait_rdone(input int target);
      int t = 0;
      while (rdone_cnt < target && t < 500) begin
         @(negedge ACLK); #1; t++;
      end
      chk("rd_done_timeout", 64'(rdone_cnt >= target), 64'(1));
   endtask

   initial begin
      int w0, r0, a0, c0, tmo;
      // Reset values
      repeat (3) @(negedge ACLK);
      #1;
      chk("rst_awvalid", 64'(AWVALID), 64'(0));
      chk("rst_wvalid", 64'(WVALID), 64'(0));
      chk("rst_arvalid", 64'(ARVALID), 64'(0));
      chk("rst_awaddr", 64'(AWADDR), 64'(0));
      chk("rst_wdata", 64'({WDATA, WSTRB}), 64'(0));
      chk("rst_araddr", 64'(ARADDR), 64'(0));
      chk("rst_rdata", 64'(read_data_o), 64'(0));
      chk("rst_resps", 64'({write_response_o, read_response_o}), 64'(0));
      chk("rst_pending", 64'({write_pending_o, read_pending_o}), 64'(0));
      chk("rst_dones", 64'({write_done_o, read_done_o}), 64'(0));
      chk("rst_readies", 64'({BREADY, RREADY}), 64'(2'b11));
      @(negedge ACLK);
      ARESETN = 1'b1;

      // Single write, zero-wait slave
      c0 = awvalid_cycles; w0 = wdone_cnt;
      push_wr(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1);
      chk("single_pending_1", 64'(write_pending_o), 64'(1));
      wait_wdone(w0 + 1);
      chk("single_pending_0", 64'(write_pending_o), 64'(0));
      chk("single_awvalid_cycles", 64'(awvalid_cycles - c0), 64'(1));

      // Fill the write queue behind a stalled transaction
      aw_wait = 1000; w0 = wdone_cnt;
      push_wr(32'h0000_0100, 32'h1111_0000, 4'h1, 2'b00, 1'b1);
      repeat (2) @(negedge ACLK);
      push_wr(32'h0000_0104, 32'h1111_0001, 4'h3, 2'b00, 1'b1);
      push_wr(32'h0000_0108, 32'h1111_0002, 4'h7, 2'b00, 1'b1);
      push_wr(32'h0000_010C, 32'h1111_0003, 4'hF, 2'b00, 1'b1);
      push_wr(32'h0000_0110, 32'h1111_0004, 4'h8, 2'b00, 1'b1);
      chk("full_ready_low", 64'(write_ready_o), 64'(0));
      chk("full_pending", 64'(write_pending_o), 64'(5));
      push_wr(32'h0000_0114, 32'h1111_0005, 4'hC, 2'b00, 1'b0);
      aw_wait = 0;
      wait_wdone(w0 + 5);
      chk("full_pending_0", 64'(write_pending_o), 64'(0));

      // Skewed handshakes: W first, then AW first
      aw_wait = 3; w_wait = 0; w0 = wdone_cnt;
      push_wr(32'h0000_0200, 32'hCAFE_0001, 4'h5, 2'b01, 1'b1);
      repeat (3) @(negedge ACLK);
      #1 chk("skew1_valids", 64'({AWVALID, WVALID}), 64'(2'b10));
      wait_wdone(w0 + 1);
      aw_wait = 0; w_wait = 3;
      push_wr(32'h0000_0204, 32'hCAFE_0002, 4'hA, 2'b00, 1'b1);
      repeat (3) @(negedge ACLK);
      #1 chk("skew2_valids", 64'({AWVALID, WVALID}), 64'(2'b01));
      wait_wdone(w0 + 2);
      repeat (6) @(negedge ACLK);
      chk("skew_done_count", 64'(wdone_cnt - w0), 64'(2));
      w_wait = 0;

      // SLVERR read flushes the queued reads; writes proceed
      r_wait = 6; w0 = wdone_cnt; r0 = rdone_cnt; a0 = ar_hs_cnt;
      push_rd(32'h2000_0000, 32'h1111_1111, 2'b10, 1'b1);
      push_rd(32'h2000_0004, 32'h0, 2'b00, 1'b0);
      push_rd(32'h2000_0008, 32'h0, 2'b00, 1'b0);
      chk("flush_pending_3", 64'(read_pending_o), 64'(3));
      push_wr(32'h0000_0300, 32'h0BAD_F00D, 4'hF, 2'b00, 1'b1);
      push_wr(32'h0000_0304, 32'h600D_F00D, 4'h3, 2'b00, 1'b1);
      wait_rdone(r0 + 1);
      chk("flush_read_pending", 64'(read_pending_o), 64'(0));
      wait_wdone(w0 + 2);
      repeat (20) @(negedge ACLK);
      #1;
      chk("flush_ar_count", 64'(ar_hs_cnt - a0), 64'(1));
      chk("flush_rdone_count", 64'(rdone_cnt - r0), 64'(1));
      chk("flush_arvalid_low", 64'(ARVALID), 64'(0));
      chk("flush_read_ready", 64'(read_ready_o), 64'(1));

      // Delayed reads; data holds between pulses
      r_wait = 5; r0 = rdone_cnt;
      push_rd(32'h2000_0010, 32'h0000_0000, 2'b00, 1'b1);
      push_rd(32'h2000_0014, 32'hFFFF_FFFF, 2'b00, 1'b1);
      push_rd(32'h2000_0018, 32'hA5A5_A5A5, 2'b00, 1'b1);
      wait_rdone(r0 + 1);
      repeat (3) @(negedge ACLK);
      chk("rd_hold_0", 64'(read_data_o), 64'(32'h0000_0000));
      wait_rdone(r0 + 2);
      repeat (3) @(negedge ACLK);
      chk("rd_hold_1", 64'(read_data_o), 64'(32'hFFFF_FFFF));
      wait_rdone(r0 + 3);
      repeat (3) @(negedge ACLK);
      chk("rd_hold_2", 64'(read_data_o), 64'(32'hA5A5_A5A5));
      chk("rd_pending_0", 64'(read_pending_o), 64'(0));

      // Reset with one write stalled on AW and two queued
      aw_wait = 1000;
      push_wr(32'h0000_0400, 32'h4444_0000, 4'hF, 2'b00, 1'b1);
      push_wr(32'h0000_0404, 32'h4444_0001, 4'hF, 2'b00, 1'b1);
      push_wr(32'h0000_0408, 32'h4444_0002, 4'hF, 2'b00, 1'b1);
      repeat (2) @(negedge ACLK);
      #1;
      chk("pre_rst_awvalid", 64'(AWVALID), 64'(1));
      chk("pre_rst_pending", 64'(write_pending_o), 64'(3));
      @(negedge ACLK);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("rst_mid_valids", 64'({AWVALID, WVALID}), 64'(0));
      chk("rst_mid_pending", 64'(write_pending_o), 64'(0));
      chk("rst_mid_bready", 64'(BREADY), 64'(1));
      exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete(); slv_b_q.delete();
      w0 = wdone_cnt;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      aw_wait = 0;
      repeat (4) @(negedge ACLK);
      chk("rst_mid_no_done", 64'(wdone_cnt - w0), 64'(0));
      push_wr(32'h0000_0500, 32'h5555_AAAA, 4'h6, 2'b00, 1'b1);
      wait_wdone(w0 + 1);
      chk("post_rst_pending", 64'(write_pending_o), 64'(0));

      // Drain and confirm every expected item was consumed
      tmo = 0;
      while ((exp_b_q.size() + exp_r_q.size()) != 0 && tmo < 1000) begin
         @(negedge ACLK); tmo++;
      end
      repeat (3) @(negedge ACLK);
      chk("scoreboard_empty", 64'(exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() +
                                   exp_ar_q.size() + exp_r_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
